// File: rtl/aes_result_sequencer.sv
// Captures a 128-bit AES result and presents each byte, in AES byte order, as 3-digit BCD.
// Define AES_RESULT_SEQ_LOOP_EN to cycle through the bytes continuously and accept recaptures at any time.
module aes_result_sequencer #(
  parameter int unsigned DWELL = 50000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] expected,
  output logic [11:0]  bcd_out,
  output logic         bcd_valid,
  output logic [3:0]   byte_idx,
  output logic         match,
  output logic         busy
);

`ifdef AES_RESULT_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int unsigned DCW = $clog2(DWELL + 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  state_t         state, next_state;
  logic [127:0]   hold;
  logic [19:0]    sr, sr_adj, sr_next;
  logic [2:0]     iter;
  logic [DCW-1:0] dwell;
  logic [3:0]     next_idx;
  logic           capture, conv_last, dwell_last, advance;

  assign in_ready   = LOOP_EN || (state == IDLE);
  assign busy       = (state != IDLE);
  assign capture    = in_valid && in_ready;
  assign conv_last  = (state == CONVERT) && (iter == 3'd7);
  assign dwell_last = (state == SHOW) && (dwell == DWELL_LAST);
  assign advance    = LOOP_EN || (byte_idx != 4'd15);
  assign next_idx   = byte_idx + 4'd1;

  // One double-dabble step on {bcd[11:0], bin[7:0]}: adjust BCD nibbles, then shift the whole word.
  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr[8 + 4*i +: 4] >= 4'd5) sr_adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
    end
    sr_next = sr_adj << 1;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture) next_state = CONVERT;
      CONVERT: if (conv_last) next_state = SHOW;
      SHOW:    if (dwell_last) next_state = advance ? CONVERT : IDLE;
      default: next_state = IDLE;
    endcase
    if (capture) next_state = CONVERT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      sr        <= '0;
      iter      <= '0;
      dwell     <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      byte_idx  <= '0;
      match     <= 1'b0;
    end else if (capture) begin
      hold      <= in_data;
      match     <= (in_data == expected);
      byte_idx  <= '0;
      sr        <= {12'h000, in_data[127:120]};
      iter      <= '0;
      bcd_valid <= 1'b0;
    end else begin
      case (state)
        CONVERT: begin
          sr   <= sr_next;
          iter <= iter + 3'd1;
          if (iter == 3'd7) begin
            bcd_out   <= sr_next[19:8];
            bcd_valid <= 1'b1;
            dwell     <= '0;
          end
        end
        SHOW: begin
          if (dwell == DWELL_LAST) begin
            bcd_valid <= 1'b0;
            if (advance) begin
              // Byte k sits at hold[8*(15-k) +: 8]; {~k,3'b0} is that offset.
              byte_idx <= next_idx;
              sr       <= {12'h000, hold[{~next_idx, 3'b000} +: 8]};
              iter     <= '0;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_result_sequencer.sv
// Self-checking bench for aes_result_sequencer: per-cycle comparison against a timeline model
// derived from the byte period, plus a DWELL=1 instance.
module tb_aes_result_sequencer;

`ifdef AES_RESULT_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam int unsigned P4 = 12;  // DWELL=4 byte period
  localparam int unsigned P1 = 9;   // DWELL=1 byte period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv4 = 1'b0, r4, bv4, m4, b4;
  logic [127:0] id4 = '0, ex4 = '0;
  logic [11:0]  bo4;
  logic [3:0]   bi4;
  logic         iv1 = 1'b0, r1, bv1, m1, b1;
  logic [127:0] id1 = '0, ex1 = '0;
  logic [11:0]  bo1;
  logic [3:0]   bi1;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [11:0] last_bcd = '0;

  aes_result_sequencer #(.DWELL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(r4), .in_data(id4), .expected(ex4),
    .bcd_out(bo4), .bcd_valid(bv4), .byte_idx(bi4), .match(m4), .busy(b4)
  );

  aes_result_sequencer #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(r1), .in_data(id1), .expected(ex1),
    .bcd_out(bo1), .bcd_valid(bv1), .byte_idx(bi1), .match(m1), .busy(b1)
  );

  function automatic logic [7:0] byte_of(input logic [127:0] d, input int unsigned k);
    logic [127:0] tmp;
    tmp = d >> (8 * (15 - k));
    return tmp[7:0];
  endfunction

  function automatic logic [11:0] ref_bcd(input logic [7:0] b);
    int v;
    v = int'(b);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Capture on u4, then compare every output each cycle up to t=to_t against the byte-period timeline.
  // A nonzero poke_at drives a second request from t=poke_at for two edges.
  task automatic run_and_check(input string name, input logic [127:0] data, input logic [127:0] exp,
                               input int unsigned to_t, input int unsigned poke_at);
    logic [11:0] prev, e_bcd;
    logic [3:0]  e_idx;
    logic        done, e_valid;
    int unsigned j;
    prev = last_bcd;
    @(negedge clk);
    iv4 = 1'b1; id4 = data; ex4 = exp;
    @(posedge clk); #1;
    iv4 = 1'b0;
    for (int unsigned t = 0; t <= to_t; t++) begin
      if (t != 0) begin @(posedge clk); #1; end
      done    = !LOOP && (t >= 16 * P4);
      e_idx   = done ? 4'd15 : 4'((t / P4) % 16);
      e_valid = !done && ((t % P4) >= 8);
      if (t < 8) e_bcd = prev;
      else begin
        j = (t - 8) / P4;
        if (!LOOP && j > 15) j = 15;
        e_bcd = ref_bcd(byte_of(data, j % 16));
      end
      checks += 6;
      if (bo4 !== e_bcd)   begin failures++; $display("FAIL %s t=%0d bcd_out got %h want %h", name, t, bo4, e_bcd); end
      if (bv4 !== e_valid) begin failures++; $display("FAIL %s t=%0d bcd_valid got %b want %b", name, t, bv4, e_valid); end
      if (bi4 !== e_idx)   begin failures++; $display("FAIL %s t=%0d byte_idx got %0d want %0d", name, t, bi4, e_idx); end
      if (m4 !== (data == exp)) begin failures++; $display("FAIL %s t=%0d match got %b want %b", name, t, m4, data == exp); end
      if (b4 !== !done)    begin failures++; $display("FAIL %s t=%0d busy got %b want %b", name, t, b4, !done); end
      if (r4 !== (LOOP || done)) begin failures++; $display("FAIL %s t=%0d in_ready got %b want %b", name, t, r4, LOOP || done); end
      if (poke_at != 0 && t == poke_at) begin
        iv4 = 1'b1; id4 = rand128(); ex4 = id4;
      end
      if (poke_at != 0 && t == poke_at + 2) iv4 = 1'b0;
      last_bcd = e_bcd;
    end
  endtask

  task automatic check_reset_values(input string name);
    checks += 6;
    if (r4 !== 1'b1)    begin failures++; $display("FAIL %s in_ready got %b want 1", name, r4); end
    if (bo4 !== 12'h0)  begin failures++; $display("FAIL %s bcd_out got %h want 000", name, bo4); end
    if (bv4 !== 1'b0)   begin failures++; $display("FAIL %s bcd_valid got %b want 0", name, bv4); end
    if (bi4 !== 4'd0)   begin failures++; $display("FAIL %s byte_idx got %0d want 0", name, bi4); end
    if (m4 !== 1'b0)    begin failures++; $display("FAIL %s match got %b want 0", name, m4); end
    if (b4 !== 1'b0)    begin failures++; $display("FAIL %s busy got %b want 0", name, b4); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    last_bcd = '0;
  endtask

  task automatic test_vector();
    logic [127:0] v;
    v = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    run_and_check("vector", v, v, LOOP ? 16 * P4 + P4 : 16 * P4 + 4, 0);
  endtask

  task automatic test_extremes();
    run_and_check("all_ff", {128{1'b1}}, '0, 16 * P4 + 2, 0);
    run_and_check("all_00", '0, '0, 16 * P4 + 2, 0);
  endtask

  task automatic test_ignored_request();
    logic [127:0] d;
    d = rand128();
    run_and_check("ignore_busy", d, ~d, 16 * P4 + 2, 3 * P4 + 9);
  endtask

  task automatic test_reset_abort();
    logic [127:0] d;
    d = rand128();
    run_and_check("pre_abort", d, d, 7 * P4 + 3, 0);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
    last_bcd = '0;
    d = rand128();
    run_and_check("post_abort", d, ~d, LOOP ? 16 * P4 + P4 : 16 * P4 + 2, 0);
  endtask

  task automatic test_loop_restart();
    logic [127:0] a, b;
    a = rand128();
    b = rand128();
    run_and_check("loop_first", a, ~a, 9 * P4 + 10, 0);
    run_and_check("loop_recap", b, b, 2 * P4 + 4, 0);
  endtask

  task automatic test_dwell1();
    logic [127:0] d;
    logic e_busy, e_valid;
    int unsigned pulses;
    d = rand128();
    pulses = 0;
    @(negedge clk);
    iv1 = 1'b1; id1 = d; ex1 = d;
    @(posedge clk); #1;
    iv1 = 1'b0;
    for (int unsigned t = 0; t <= 150; t++) begin
      if (t != 0) begin @(posedge clk); #1; end
      e_busy  = LOOP || (t < 16 * P1);
      e_valid = e_busy && ((t % P1) == 8);
      if (bv1) pulses++;
      checks += 2;
      if (bv1 !== e_valid) begin failures++; $display("FAIL dwell1 t=%0d bcd_valid got %b want %b", t, bv1, e_valid); end
      if (b1 !== e_busy)   begin failures++; $display("FAIL dwell1 t=%0d busy got %b want %b", t, b1, e_busy); end
      if (e_valid) begin
        checks++;
        if (bo1 !== ref_bcd(byte_of(d, (t / P1) % 16)))
          begin failures++; $display("FAIL dwell1 t=%0d bcd_out got %h want %h", t, bo1, ref_bcd(byte_of(d, (t / P1) % 16))); end
      end
    end
    checks++;
    if (pulses != 16) begin failures++; $display("FAIL dwell1_pulses got %0d want 16", pulses); end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_extremes();
`ifndef AES_RESULT_SEQ_LOOP_EN
    test_ignored_request();
`endif
    test_reset_abort();
`ifdef AES_RESULT_SEQ_LOOP_EN
    test_loop_restart();
`endif
    test_dwell1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
